// File: rtl/var_rate_gen_if.sv
// Period-write port of var_rate_gen: valid/ready handshake carrying
// the target channel and the new period.
interface var_rate_gen_if #(
    parameter int unsigned CH    = 4,
    parameter int unsigned WIDTH = 33
);
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

    logic             CFG_VALID;
    logic [CHW-1:0]   CFG_CH;
    logic [WIDTH-1:0] CFG_MAX;
    logic             CFG_READY;

    modport master (output CFG_VALID, output CFG_CH, output CFG_MAX, input  CFG_READY);
    modport slave  (input  CFG_VALID, input  CFG_CH, input  CFG_MAX, output CFG_READY);
endinterface

// File: rtl/var_rate_gen.sv
// Multi-channel programmable rate generator: per-channel divider with
// square-wave or pulse output and boundary-aligned period updates.
module var_rate_gen #(
    parameter int unsigned CH    = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic          DIV_CLK,
    input  logic          RST_N,
    input  logic [CH-1:0] EN,
    input  logic [CH-1:0] MODE,
    var_rate_gen_if.slave cfg,
    output logic [CH-1:0] RATE_OUT,
    output logic [CH-1:0] TICK
);
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [CH-1:0][WIDTH-1:0] per_q, per_d;
    logic [CH-1:0][WIDTH-1:0] shd_q, shd_d;
    logic [CH-1:0]            pend_q, pend_d;
    logic [CH-1:0]            rate_q, rate_d;
    logic [CH-1:0]            tick_q, tick_d;
    logic [CH-1:0]            run, term, wr;
    logic                     ready;

    // Out-of-range CFG_CH never matches any channel, so ready stays low.
    always_comb begin
        ready = 1'b0;
        for (int unsigned c = 0; c < CH; c++) begin
            if (cfg.CFG_CH == CHW'(c) && !pend_q[c]) begin
                ready = 1'b1;
            end
        end
    end

    assign cfg.CFG_READY = ready;

    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        rate_d = rate_q;
        tick_d = tick_q;
        run    = '0;
        term   = '0;
        wr     = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            run[c]  = EN[c] && (per_q[c] != '0);
            term[c] = run[c] && (cnt_q[c] == per_q[c] - WIDTH'(1));
            wr[c]   = cfg.CFG_VALID && ready && (cfg.CFG_CH == CHW'(c));
            if (run[c]) begin
                cnt_d[c]  = term[c] ? '0 : cnt_q[c] + WIDTH'(1);
                tick_d[c] = term[c];
                rate_d[c] = MODE[c] ? term[c] : (rate_q[c] ^ term[c]);
                if (term[c] && pend_q[c]) begin
                    per_d[c]  = shd_q[c];
                    pend_d[c] = 1'b0;
                end
                // wr implies pend_q==0, so this never collides with the swap above
                if (wr[c]) begin
                    shd_d[c]  = cfg.CFG_MAX;
                    pend_d[c] = 1'b1;
                end
            end else begin
                cnt_d[c]  = '0;
                rate_d[c] = 1'b0;
                tick_d[c] = 1'b0;
                if (pend_q[c]) begin
                    per_d[c]  = shd_q[c];
                    pend_d[c] = 1'b0;
                end
                if (wr[c]) begin
                    per_d[c] = cfg.CFG_MAX;
                end
            end
        end
    end

    always_ff @(posedge DIV_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            per_q  <= '0;
            shd_q  <= '0;
            pend_q <= '0;
            rate_q <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            rate_q <= rate_d;
            tick_q <= tick_d;
        end
    end

    assign RATE_OUT = rate_q;
    assign TICK     = tick_q;
endmodule

// File: tb/tb_var_rate_gen.sv
// Scoreboard bench for var_rate_gen with three channels, so that an
// out-of-range channel number is encodable on CFG_CH.
module tb_var_rate_gen;
    localparam int unsigned CH    = 3;
    localparam int unsigned WIDTH = 33;

    typedef struct {
        int   ch;
        logic rate;
        logic tick;
    } exp_t;

    logic          DIV_CLK;
    logic          RST_N;
    logic [CH-1:0] EN;
    logic [CH-1:0] MODE;
    logic [CH-1:0] RATE_OUT;
    logic [CH-1:0] TICK;

    int   total;
    int   bad;
    exp_t sb[$];
    exp_t e;

    var_rate_gen_if #(.CH(CH), .WIDTH(WIDTH)) cfg_if ();

    var_rate_gen #(.CH(CH), .WIDTH(WIDTH)) dut (
        .DIV_CLK  (DIV_CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .MODE     (MODE),
        .cfg      (cfg_if),
        .RATE_OUT (RATE_OUT),
        .TICK     (TICK)
    );

    initial begin
        DIV_CLK = 1'b0;
        forever #5 DIV_CLK = ~DIV_CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, summary not reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge DIV_CLK);
        #1;
    endtask

    task automatic push(input int ch, input bit rate, input bit tick);
        exp_t x;
        x.ch = ch; x.rate = rate; x.tick = tick;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; EN = '0; MODE = '0;
        cfg_if.CFG_VALID = 1'b0; cfg_if.CFG_CH = 2'd0; cfg_if.CFG_MAX = '0;
        #2;
        total++;
        if (RATE_OUT !== 3'b000 || TICK !== 3'b000) begin
            bad++; $display("FAIL reset_out: rate=%b tick=%b want 000/000", RATE_OUT, TICK);
        end
        total++;
        if (cfg_if.CFG_READY !== 1'b1) begin
            bad++; $display("FAIL reset_ready_ch0: got %b want 1", cfg_if.CFG_READY);
        end
        cfg_if.CFG_CH = 2'd3;
        #1;
        total++;
        if (cfg_if.CFG_READY !== 1'b0) begin
            bad++; $display("FAIL reset_ready_ch3: got %b want 0", cfg_if.CFG_READY);
        end
        cfg_if.CFG_CH = 2'd0;
        cyc();
        RST_N = 1'b1;
    endtask

    // Idle write of P to channel ch, checking acceptance and quiet outputs.
    task automatic idle_write(input int ch, input logic [WIDTH-1:0] p);
        cfg_if.CFG_VALID = 1'b1; cfg_if.CFG_CH = 2'(ch); cfg_if.CFG_MAX = p;
        #1;
        total++;
        if (cfg_if.CFG_READY !== 1'b1) begin
            bad++; $display("FAIL idle_write_ready ch%0d: got %b want 1", ch, cfg_if.CFG_READY);
        end
        cyc();
        cfg_if.CFG_VALID = 1'b0;
        total++;
        if (RATE_OUT[ch] !== 1'b0 || TICK[ch] !== 1'b0) begin
            bad++; $display("FAIL idle_write_out ch%0d: rate=%b tick=%b want 0/0", ch, RATE_OUT[ch], TICK[ch]);
        end
    endtask

    task automatic test_toggle();
        idle_write(0, 3);
        EN[0] = 1'b1; MODE[0] = 1'b0;
        for (int k = 1; k <= 12; k++) push(0, ((k / 3) % 2) == 1, (k % 3) == 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL toggle edge%0d: rate=%b tick=%b want %b/%b", k, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
        end
        EN[0] = 1'b0;
    endtask

    task automatic test_pulse();
        MODE[1] = 1'b1;
        idle_write(1, 1);
        EN[1] = 1'b1;
        for (int k = 1; k <= 3; k++) push(1, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL pulse_p1 edge%0d: rate=%b tick=%b want %b/%b", k, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
        end
        // Write P=4 while running: old P=1 boundary swaps it in one edge later.
        for (int i = 0; i < 10; i++) push(1, i == 0 || i == 1 || i == 5 || i == 9, i == 0 || i == 1 || i == 5 || i == 9);
        for (int i = 0; i < 10; i++) begin
            cfg_if.CFG_VALID = (i == 0); cfg_if.CFG_CH = 2'd1; cfg_if.CFG_MAX = 4;
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL pulse_p4 step%0d: rate=%b tick=%b want %b/%b", i, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
            if (i < 2) begin
                total++;
                if (cfg_if.CFG_READY !== (i == 1)) begin
                    bad++; $display("FAIL pulse_ready step%0d: got %b want %b", i, cfg_if.CFG_READY, i == 1);
                end
            end
        end
        cfg_if.CFG_VALID = 1'b0;
        EN[1] = 1'b0; MODE[1] = 1'b0;
    endtask

    task automatic test_period_change();
        bit exp_rdy;
        idle_write(0, 5);
        EN[0] = 1'b1; MODE[0] = 1'b0;
        for (int k = 1; k <= 12; k++)
            push(0, (k >= 5 && k <= 6) || (k >= 9 && k <= 10), k == 5 || k == 7 || k == 9 || k == 11);
        for (int k = 1; k <= 12; k++) begin
            cfg_if.CFG_VALID = (k == 2); cfg_if.CFG_CH = 2'd0; cfg_if.CFG_MAX = 2;
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL change edge%0d: rate=%b tick=%b want %b/%b", k, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
            exp_rdy = !(k >= 2 && k <= 4);
            total++;
            if (cfg_if.CFG_READY !== exp_rdy) begin
                bad++; $display("FAIL change_ready edge%0d: got %b want %b", k, cfg_if.CFG_READY, exp_rdy);
            end
        end
        cfg_if.CFG_VALID = 1'b0;
    endtask

    // ch0 left at P=2 with CNT=1: a drop must clear it, else re-enable ticks early.
    task automatic test_en_drop();
        EN[0] = 1'b0;
        push(0, 0, 0); push(0, 0, 0);
        push(0, 0, 0); push(0, 1, 1); push(0, 1, 0); push(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) EN[0] = 1'b1;
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL en_drop step%0d: rate=%b tick=%b want %b/%b", i, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
        end
    endtask

    task automatic test_terminal_write();
        MODE[2] = 1'b1;
        idle_write(2, 3);
        EN[2] = 1'b1;
        for (int k = 1; k <= 10; k++) push(2, k == 3 || k == 6 || k == 8 || k == 10, k == 3 || k == 6 || k == 8 || k == 10);
        for (int k = 1; k <= 10; k++) begin
            cfg_if.CFG_VALID = (k == 3); cfg_if.CFG_CH = 2'd2; cfg_if.CFG_MAX = 2;
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL term_write edge%0d: rate=%b tick=%b want %b/%b", k, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
        end
        cfg_if.CFG_VALID = 1'b0;
    endtask

    task automatic test_bad_channel();
        cfg_if.CFG_VALID = 1'b1; cfg_if.CFG_CH = 2'd3; cfg_if.CFG_MAX = 1;
        for (int j = 1; j <= 4; j++) push(2, (j % 2) == 0, (j % 2) == 0);
        for (int j = 1; j <= 4; j++) begin
            #1;
            total++;
            if (cfg_if.CFG_READY !== 1'b0) begin
                bad++; $display("FAIL bad_ch_ready step%0d: got %b want 0", j, cfg_if.CFG_READY);
            end
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick) begin
                bad++; $display("FAIL bad_ch_run step%0d: rate=%b tick=%b want %b/%b", j, RATE_OUT[e.ch], TICK[e.ch], e.rate, e.tick);
            end
        end
        cfg_if.CFG_VALID = 1'b0; cfg_if.CFG_CH = 2'd0;
    endtask

    task automatic test_reset_mid();
        cfg_if.CFG_VALID = 1'b1; cfg_if.CFG_CH = 2'd2; cfg_if.CFG_MAX = 5;
        cyc();
        cfg_if.CFG_VALID = 1'b0;
        #1;
        total++;
        if (cfg_if.CFG_READY !== 1'b0) begin
            bad++; $display("FAIL pre_reset_pend: ready=%b want 0", cfg_if.CFG_READY);
        end
        RST_N = 1'b0;
        #1;
        total++;
        if (RATE_OUT !== 3'b000 || TICK !== 3'b000) begin
            bad++; $display("FAIL reset_mid_out: rate=%b tick=%b want 000/000", RATE_OUT, TICK);
        end
        total++;
        if (cfg_if.CFG_READY !== 1'b1) begin
            bad++; $display("FAIL reset_mid_ready: got %b want 1", cfg_if.CFG_READY);
        end
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (RATE_OUT !== 3'b000 || TICK !== 3'b000) begin
                bad++; $display("FAIL post_reset_idle step%0d: rate=%b tick=%b want 000/000", i, RATE_OUT, TICK);
            end
        end
        idle_write(2, 2);
        push(2, 0, 0); push(2, 1, 1); push(2, 0, 0); push(2, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            e = sb.pop_front();
            total++;
            if (RATE_OUT[e.ch] !== e.rate || TICK[e.ch] !== e.tick || RATE_OUT[0] !== 1'b0) begin
                bad++; $display("FAIL rewrite step%0d: rate=%b tick=%b want ch2 %b/%b ch0 rate 0", i, RATE_OUT, TICK, e.rate, e.tick);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_toggle();
        test_pulse();
        test_period_change();
        test_en_drop();
        test_terminal_write();
        test_bad_channel();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/var_rate_gen.md
# var_rate_gen

Multi-channel programmable rate generator, parametrised successor of the single-channel variable clock divider. Each of `CH` channels divides `DIV_CLK` by a runtime period and produces either a square wave (toggle mode) or a one-cycle pulse train (pulse mode), plus a per-channel period-end strobe. New periods are written through a valid/ready port into a per-channel shadow register and take effect only at a period boundary, so output waveforms never glitch. Sits between the rate driver logic and downstream blocks (stabiliser, display scan, LED blink).

## Interface
- `CH`, 4, number of independent channels (≥1)
- `WIDTH`, 33, width of period values and counters (≥2)
- `CHW`, `$clog2(CH)` (min 1), width of `CFG_CH` (derived, not overridden)

- `DIV_CLK`  in  1  sole clock, rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `EN`  in  CH  per-channel enable
- `MODE`  in  CH  per-channel mode: 0 = toggle/square, 1 = pulse
- `CFG_VALID`  in  1  period write request
- `CFG_CH`  in  CHW  target channel of write
- `CFG_MAX`  in  WIDTH  new period P, in `DIV_CLK` cycles
- `CFG_READY`  out  1  write accepted this cycle when high with `CFG_VALID`
- `RATE_OUT`  out  CH  per-channel divided output, registered
- `TICK`  out  CH  per-channel one-cycle period-end strobe, registered

## Operation
- Per-channel state: `CNT[WIDTH]`, active period `PER[WIDTH]`, shadow `SHD[WIDTH]`, pending flag `PEND`.
- Channel is *running* when `EN`=1 and `PER`≠0; otherwise *idle*.
- Running: `CNT` increments by 1 per edge; terminal when `CNT == PER-1`; on terminal `CNT`←0 and `TICK`←1, else `TICK`←0.
- Toggle mode: `RATE_OUT` inverts on each terminal edge → output period 2·P cycles, 50% duty.
- Pulse mode: `RATE_OUT` ← terminal (same value as `TICK`) → one-cycle high every P cycles; P=1 gives constant high.
- `MODE` is evaluated every edge; a change takes effect on the next edge with no counter reset.
- Idle: `CNT`←0, `RATE_OUT`←0, `TICK`←0 (synchronous clear while idle).
- `CFG_READY` = (`CFG_CH` < `CH`) AND NOT `PEND[CFG_CH]`; combinational from `CFG_CH` and state.
- Accepted write (`CFG_VALID` & `CFG_READY`):
  - target idle → `CFG_MAX` loads directly into `PER`; `PEND` stays 0.
  - target running → `CFG_MAX` into `SHD`, `PEND`←1.
- Running channel with `PEND`=1 at a terminal edge: `PER`←`SHD`, `PEND`←0; new period governs the next count.
- Idle channel with `PEND`=1: `PER`←`SHD`, `PEND`←0 on the next edge.
- Write to a running channel in its own terminal cycle: lands in `SHD` and applies at the *following* terminal, not the current one.
- Write with `CFG_CH` ≥ `CH` or `PEND` set: `CFG_READY`=0; nothing changes.
- Writing P=0 to a running channel: applied at terminal; channel then goes idle (outputs cleared next edge).
- All arithmetic is unsigned modulo 2^WIDTH; maximum P = 2^WIDTH−1; `CNT` never exceeds `PER`−1.

## Timing
- Reset (`RST_N`=0, asynchronous, no clock needed): `CNT`, `PER`, `SHD`, `PEND`, `RATE_OUT`, `TICK` all 0. `CFG_READY` = (`CFG_CH` < `CH`).
- Reset mid-period discards `SHD` and the pending update; channel is idle after release until a period is written.
- First `TICK` appears after P rising edges of running state, counted from the first edge with `EN`=1 and `PER`=P.
- `TICK`/`RATE_OUT` change only on rising `DIV_CLK`; no combinational path from inputs to either.
- `CFG_READY` can drop the cycle after an accepted write to a running channel and rises the cycle after that channel's terminal edge.
- Channels are fully independent; simultaneous terminals and writes on different channels do not interact.

## Test plan
- Reset, write P=3 to ch0 while idle, then `EN[0]`=1, `MODE[0]`=0 → `RATE_OUT[0]` toggles every 3 cycles (period 6), `TICK[0]` high 1 cycle in 3; first `TICK` after 3rd enabled edge.
- ch1 pulse mode, P=1 → `RATE_OUT[1]` and `TICK[1]` constant 1; P=4 → high 1 cycle in 4.
- ch0 running P=5; write P=2 mid-period → `CFG_READY` low until terminal; current period completes at 5 cycles, next periods 2 cycles; no runt pulse.
- Write to ch2 in exactly its terminal cycle → the current boundary keeps the old P; the new P applies from the boundary after; write with `CFG_CH`=CH → `CFG_READY`=0, no effect.
- `EN` drop mid-count → outputs 0 next edge, `CNT` cleared; re-enable → full P cycles to first `TICK`.
- Assert `RST_N`=0 mid-period between clock edges → all outputs 0 immediately; after release, channels are idle with `PER`=0 until a period is rewritten.
